// File: rtl/alu_sched_if.sv
// Requester and ALU bus bundle for the shared-ALU scheduler.
// The slave side is the scheduler; the master side is the requesters plus the ALU.
interface alu_sched_if;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] result;
    logic        zero_out;
    logic        busy;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_out;
    logic        alu_zero;

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, alu_out, alu_zero,
        output gnt0, gnt1, done0, done1, result, zero_out, busy, alu_op, alu_a, alu_b
    );

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, alu_out, alu_zero,
        input  gnt0, gnt1, done0, done1, result, zero_out, busy, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler for two ports sharing one combinational 16-bit ALU.
// Native ops take a single EXEC pass; opcode 7 runs four nibble-parity passes.
module alu_sched (
    input  logic        i_clk,
    input  logic        i_rst_n,
    alu_sched_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_PAR} state_t;

    localparam logic [2:0] OP_PAR   = 3'd7;
    localparam logic [2:0] OP_NIBP  = 3'd2;
    localparam logic [2:0] OP_IDLE  = 3'd6;

    state_t      r_state, w_next;
    logic        r_last, r_own;
    logic [2:0]  r_opr;
    logic [15:0] r_ar, r_br;
    logic [1:0]  r_pc;
    logic        r_acc;
    logic        r_gnt0, r_gnt1, r_done0, r_done1;
    logic [15:0] r_result;
    logic        r_zero;

    logic        w_any, w_win, w_accept, w_par_bit;
    logic [2:0]  w_win_op;
    logic [15:0] w_win_a, w_win_b;
    logic [2:0]  w_alu_op;
    logic [15:0] w_alu_a, w_alu_b;

    // On a tie the port that was not served last wins.
    assign w_any     = bus.req0 | bus.req1;
    assign w_win     = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
    assign w_win_op  = w_win ? bus.op1 : bus.op0;
    assign w_win_a   = w_win ? bus.a1  : bus.a0;
    assign w_win_b   = w_win ? bus.b1  : bus.b0;
    assign w_par_bit = r_acc ^ bus.alu_out[0];

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_alu_op = OP_IDLE;
        w_alu_a  = 16'h0000;
        w_alu_b  = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_accept = 1'b1;
                    w_next   = (w_win_op == OP_PAR) ? S_PAR : S_EXEC;
                end
            end
            S_EXEC: begin
                w_alu_op = r_opr;
                w_alu_a  = r_ar;
                w_alu_b  = r_br;
                w_next   = S_IDLE;
            end
            S_PAR: begin
                w_alu_op = OP_NIBP;
                w_alu_a  = r_ar;
                w_alu_b  = {14'b0, r_pc};
                if (r_pc == 2'd3) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_own    <= 1'b0;
            r_opr    <= 3'd0;
            r_ar     <= 16'h0000;
            r_br     <= 16'h0000;
            r_pc     <= 2'd0;
            r_acc    <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_result <= 16'h0000;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (w_accept) begin
                r_opr  <= w_win_op;
                r_ar   <= w_win_a;
                r_br   <= w_win_b;
                r_own  <= w_win;
                r_last <= w_win;
                r_gnt0 <= ~w_win;
                r_gnt1 <= w_win;
                r_pc   <= 2'd0;
                r_acc  <= 1'b0;
            end
            if (r_state == S_EXEC) begin
                r_result <= bus.alu_out;
                r_zero   <= bus.alu_zero;
                r_done0  <= ~r_own;
                r_done1  <= r_own;
            end
            // Parity flag is computed here from the accumulator, not taken from ALU_ZERO.
            if (r_state == S_PAR) begin
                r_acc <= w_par_bit;
                r_pc  <= r_pc + 2'd1;
                if (r_pc == 2'd3) begin
                    r_result <= {15'b0, w_par_bit};
                    r_zero   <= ~w_par_bit;
                    r_done0  <= ~r_own;
                    r_done1  <= r_own;
                end
            end
        end
    end

    assign bus.gnt0     = r_gnt0;
    assign bus.gnt1     = r_gnt1;
    assign bus.done0    = r_done0;
    assign bus.done1    = r_done1;
    assign bus.result   = r_result;
    assign bus.zero_out = r_zero;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.alu_op   = w_alu_op;
    assign bus.alu_a    = w_alu_a;
    assign bus.alu_b    = w_alu_b;
endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioral ALU hanging off the bus.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_sched;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    alu_sched_if bus ();

    alu_sched dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: 0 add, 1 sub, 2 parity of nibble B[1:0] of A, 3 and, 4 or, 5 xor, 6 pass B.
    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] sh;
        sh = a >> {b[1:0], 2'b00};
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return {15'b0, ^sh[3:0]};
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return b;
            default: return 16'h0000;
        endcase
    endfunction

    assign bus.alu_out  = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_zero = (bus.alu_out == 16'h0000);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0  = 3'd0; bus.op1  = 3'd0;
        bus.a0 = 16'h0; bus.b0 = 16'h0; bus.a1 = 16'h0; bus.b1 = 16'h0;

        // reset for two cycles
        tick(); tick();
        chk("rst_gnt0",  bus.gnt0, 0);
        chk("rst_gnt1",  bus.gnt1, 0);
        chk("rst_done0", bus.done0, 0);
        chk("rst_done1", bus.done1, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_res",   bus.result, 16'h0000);
        chk("rst_zero",  bus.zero_out, 0);
        chk("rst_aluop", bus.alu_op, 3'd6);
        chk("rst_alua",  bus.alu_a, 16'h0000);
        chk("rst_alub",  bus.alu_b, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", bus.busy, 0);

        // native ADD on port 0
        bus.req0 = 1'b1; bus.op0 = 3'd0; bus.a0 = 16'h00FF; bus.b0 = 16'h0001;
        tick();
        chk("add_gnt0",  bus.gnt0, 1);
        chk("add_gnt1",  bus.gnt1, 0);
        chk("add_busy",  bus.busy, 1);
        chk("add_done0_early", bus.done0, 0);
        chk("add_aluop", bus.alu_op, 3'd0);
        chk("add_alua",  bus.alu_a, 16'h00FF);
        chk("add_alub",  bus.alu_b, 16'h0001);
        bus.req0 = 1'b0;
        tick();
        chk("add_done0", bus.done0, 1);
        chk("add_done1", bus.done1, 0);
        chk("add_gnt0_off", bus.gnt0, 0);
        chk("add_res",   bus.result, 16'h0100);
        chk("add_zero",  bus.zero_out, 0);
        chk("add_busy_off", bus.busy, 0);

        // SUB to zero on port 1
        bus.req1 = 1'b1; bus.op1 = 3'd1; bus.a1 = 16'h1234; bus.b1 = 16'h1234;
        tick();
        chk("sub_gnt1", bus.gnt1, 1);
        chk("sub_gnt0", bus.gnt0, 0);
        bus.req1 = 1'b0;
        tick();
        chk("sub_done1", bus.done1, 1);
        chk("sub_done0", bus.done0, 0);
        chk("sub_res",   bus.result, 16'h0000);
        chk("sub_zero",  bus.zero_out, 1);

        // parity of F00B = 1
        bus.req0 = 1'b1; bus.op0 = 3'd7; bus.a0 = 16'hF00B; bus.b0 = 16'h0000;
        tick();
        chk("par_gnt0",  bus.gnt0, 1);
        chk("par_aluop", bus.alu_op, 3'd2);
        chk("par_alua",  bus.alu_a, 16'hF00B);
        chk("par_alub0", bus.alu_b, 16'd0);
        bus.req0 = 1'b0;
        tick();
        chk("par_alub1", bus.alu_b, 16'd1);
        chk("par_busy",  bus.busy, 1);
        tick();
        chk("par_alub2", bus.alu_b, 16'd2);
        tick();
        chk("par_alub3", bus.alu_b, 16'd3);
        chk("par_done_early", bus.done0, 0);
        tick();
        chk("par_done0", bus.done0, 1);
        chk("par_res",   bus.result, 16'h0001);
        chk("par_zero",  bus.zero_out, 0);
        chk("par_idle",  bus.busy, 0);

        // parity of 8001 = 0
        bus.req0 = 1'b1; bus.op0 = 3'd7; bus.a0 = 16'h8001;
        tick();
        chk("par2_gnt0", bus.gnt0, 1);
        bus.req0 = 1'b0;
        tick(); tick(); tick(); tick();
        chk("par2_done0", bus.done0, 1);
        chk("par2_res",   bus.result, 16'h0000);
        chk("par2_zero",  bus.zero_out, 1);

        // round-robin with both ports held; reset first so LAST=1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.op0 = 3'd6; bus.b0 = 16'h1111;
        bus.req1 = 1'b1; bus.op1 = 3'd6; bus.b1 = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr%0d_gnt0", i), bus.gnt0, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_gnt1", i), bus.gnt1, (i % 2 == 1) ? 1 : 0);
            tick();
            chk($sformatf("rr%0d_done0", i), bus.done0, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_done1", i), bus.done1, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("rr%0d_res", i), bus.result, (i % 2 == 0) ? 16'h1111 : 16'h2222);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        chk("rr_quiet_busy", bus.busy, 0);

        // reset during the third parity cycle
        bus.req0 = 1'b1; bus.op0 = 3'd7; bus.a0 = 16'hF00B;
        tick();
        chk("abort_gnt0", bus.gnt0, 1);
        bus.req0 = 1'b0;
        tick(); tick();
        chk("abort_alub2", bus.alu_b, 16'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy",  bus.busy, 0);
        chk("abort_done0", bus.done0, 0);
        chk("abort_res",   bus.result, 16'h0000);
        chk("abort_aluop", bus.alu_op, 3'd6);
        tick();
        chk("abort_done0_late", bus.done0, 0);
        chk("abort_res_late",   bus.result, 16'h0000);

        // tie right after reset goes to port 0; port 1 keeps requesting and is served next
        bus.req0 = 1'b1; bus.op0 = 3'd6; bus.b0 = 16'h0F0F;
        bus.req1 = 1'b1; bus.op1 = 3'd6; bus.b1 = 16'h5A5A;
        tick();
        chk("post_gnt0", bus.gnt0, 1);
        chk("post_gnt1", bus.gnt1, 0);
        bus.req0 = 1'b0;
        tick();
        chk("post_done0", bus.done0, 1);
        chk("post_res0",  bus.result, 16'h0F0F);
        tick();
        chk("post_gnt1b", bus.gnt1, 1);
        bus.req1 = 1'b0;
        tick();
        chk("post_done1", bus.done1, 1);
        chk("post_res1",  bus.result, 16'h5A5A);
        chk("post_zero1", bus.zero_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
